// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module  : mem_bus_arbiter_if
// Purpose : CPU, debug and memory port bundle shared by the memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
    logic        cpu_re_L;
    logic        cpu_we_L;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [15:0] dbg_addr;
    logic [15:0] dbg_wdata;
    logic [15:0] dbg_rdata;
    logic        dbg_ack;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re_L;
    logic        mem_we_L;
    logic [15:0] mem_rdata;

    // Arbiter side.
    modport master (
        input  cpu_re_L, cpu_we_L, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_re_L, mem_we_L
    );

    // Requester / memory side.
    modport slave (
        output cpu_re_L, cpu_we_L, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_re_L, mem_we_L
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one wait-stated memory port between the CPU datapath and a
//           debug/DMA requester, with bounded starvation of the debug port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_bus_arbiter_if.master bus
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_cnt_last   = CW'(WAIT_CYCLES);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   cpu_rdata_q, cpu_rdata_d;
    logic [15:0]   dbg_rdata_q, dbg_rdata_d;
    logic          re_l_q, re_l_d;
    logic          we_l_q, we_l_d;

    logic w_cpu_req;
    logic w_last;
    logic w_cpu_last;
    logic w_dbg_last;

    assign w_cpu_req  = ~bus.cpu_re_L | ~bus.cpu_we_L;
    assign w_last     = (cnt_q == c_cnt_last);
    assign w_cpu_last = (state_q == ST_CPU) && w_last;
    assign w_dbg_last = (state_q == ST_DBG) && w_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            re_l_q      <= 1'b1;
            we_l_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            re_l_q      <= re_l_d;
            we_l_q      <= we_l_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        re_l_d      = re_l_q;
        we_l_d      = we_l_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_cpu_req && !(bus.dbg_req && (starve_q == c_starve_max))) begin
                    state_d = ST_CPU;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    // Both strobes low from the datapath resolves to a write.
                    we_l_d  = bus.cpu_we_L;
                    re_l_d  = ~bus.cpu_we_L;
                    // Reaching here with dbg_req high implies starve is below its limit.
                    if (bus.dbg_req) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (bus.dbg_req) begin
                    state_d  = ST_DBG;
                    addr_d   = bus.dbg_addr;
                    wdata_d  = bus.dbg_wdata;
                    we_l_d   = ~bus.dbg_we;
                    re_l_d   = bus.dbg_we;
                    starve_d = '0;
                end
            end
            ST_CPU, ST_DBG: begin
                if (w_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    re_l_d  = 1'b1;
                    we_l_d  = 1'b1;
                    if (!re_l_q) begin
                        if (state_q == ST_CPU) begin
                            cpu_rdata_d = bus.mem_rdata;
                        end else begin
                            dbg_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                re_l_d  = 1'b1;
                we_l_d  = 1'b1;
            end
        endcase
    end

    // Read data bypasses straight from memory in the final cycle so MDR can load then.
    assign bus.cpu_stall = w_cpu_req & ~w_cpu_last;
    assign bus.cpu_rdata = (w_cpu_last && !re_l_q) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dbg_ack   = w_dbg_last;
    assign bus.dbg_rdata = (w_dbg_last && !re_l_q) ? bus.mem_rdata : dbg_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_re_L  = re_l_q;
    assign bus.mem_we_L  = we_l_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Purpose : Self-checking bench for mem_bus_arbiter (vectors, corner cases, random).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int W  = 2;
    localparam int SL = 2;

    logic clk;
    logic rst;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .WAIT_CYCLES (W),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        re_l;
        logic        we_l;
        logic [15:0] caddr;
        logic [15:0] cwd;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwd;
        logic [15:0] mrd;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        stall;
        logic        mre;
        logic        mwe;
        logic        ack;
        logic [15:0] crd;
        logic [15:0] drd;
        logic [15:0] maddr;
        logic [15:0] mwd;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an access is just "cycles left before the port frees up".
    int          m_left;
    int          m_starve;
    bit          m_dbg;
    bit          m_wr;
    logic [15:0] m_addr, m_wdata, m_crd, m_drd;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic re_l, input logic we_l,
                               input logic [15:0] caddr, input logic [15:0] cwd,
                               input logic dreq, input logic dwe,
                               input logic [15:0] daddr, input logic [15:0] mrd);
        in_t v;
        v.rst   = 1'b0;
        v.re_l  = re_l;
        v.we_l  = we_l;
        v.caddr = caddr;
        v.cwd   = cwd;
        v.dreq  = dreq;
        v.dwe   = dwe;
        v.daddr = daddr;
        v.dwd   = 16'h0000;
        v.mrd   = mrd;
        return v;
    endfunction

    task automatic model_reset();
        m_left   = 0;
        m_starve = 0;
        m_dbg    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = 16'h0000;
        m_wdata  = 16'h0000;
        m_crd    = 16'h0000;
        m_drd    = 16'h0000;
    endtask

    // One clock cycle: drive at negedge, check against the model, advance the model.
    task automatic step(input in_t v);
        logic creq;
        logic last;
        @(negedge clk);
        rst           = v.rst;
        bus.cpu_re_L  = v.re_l;
        bus.cpu_we_L  = v.we_l;
        bus.cpu_addr  = v.caddr;
        bus.cpu_wdata = v.cwd;
        bus.dbg_req   = v.dreq;
        bus.dbg_we    = v.dwe;
        bus.dbg_addr  = v.daddr;
        bus.dbg_wdata = v.dwd;
        bus.mem_rdata = v.mrd;
        #1;
        if (v.rst) model_reset();
        creq = !v.re_l || !v.we_l;
        last = (m_left == 1);
        chk("cpu_stall", 16'(bus.cpu_stall), 16'(creq && !(last && !m_dbg)));
        chk("mem_re_L",  16'(bus.mem_re_L),  16'(!(m_left > 0 && !m_wr)));
        chk("mem_we_L",  16'(bus.mem_we_L),  16'(!(m_left > 0 && m_wr)));
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("dbg_ack",   16'(bus.dbg_ack), 16'(last && m_dbg));
        chk("cpu_rdata", bus.cpu_rdata, (last && !m_dbg && !m_wr) ? v.mrd : m_crd);
        chk("dbg_rdata", bus.dbg_rdata, (last && m_dbg && !m_wr) ? v.mrd : m_drd);
        if (!v.rst) begin
            if (m_left > 0) begin
                if (last && !m_wr) begin
                    if (m_dbg) m_drd = v.mrd;
                    else       m_crd = v.mrd;
                end
                m_left--;
            end else if (creq && !(v.dreq && m_starve == SL)) begin
                m_left  = W + 1;
                m_dbg   = 1'b0;
                m_wr    = !v.we_l;
                m_addr  = v.caddr;
                m_wdata = v.cwd;
                if (v.dreq && m_starve < SL) m_starve++;
            end else if (v.dreq) begin
                m_left   = W + 1;
                m_dbg    = 1'b1;
                m_wr     = v.dwe;
                m_addr   = v.daddr;
                m_wdata  = v.dwd;
                m_starve = 0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv[20];
        in_t  idle, s;
        int   ack_k, done1, done2, lowcnt, stall_done;

        rst           = 1'b1;
        bus.cpu_re_L  = 1'b1;
        bus.cpu_we_L  = 1'b1;
        bus.cpu_addr  = 16'h0;
        bus.cpu_wdata = 16'h0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 16'h0;
        bus.dbg_wdata = 16'h0;
        bus.mem_rdata = 16'h0;
        model_reset();

        idle = mk(1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        s = idle;
        s.rst = 1'b1;
        step(s);
        step(s);

        // CPU read, CPU write, debug read, CPU read+write strobes together.
        tv[0]  = '{mk(1'b0,1'b1,16'h0040,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b1,1'b1,1'b1,1'b0,16'h0000,16'h0000,16'h0000,16'h0000};
        tv[1]  = '{mk(1'b0,1'b1,16'h0040,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b1,1'b0,1'b1,1'b0,16'h0000,16'h0000,16'h0040,16'h0000};
        tv[2]  = '{mk(1'b0,1'b1,16'h0040,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b1,1'b0,1'b1,1'b0,16'h0000,16'h0000,16'h0040,16'h0000};
        tv[3]  = '{mk(1'b0,1'b1,16'h0040,16'h0,1'b0,1'b0,16'h0,16'hBEEF), 1'b0,1'b0,1'b1,1'b0,16'hBEEF,16'h0000,16'h0040,16'h0000};
        tv[4]  = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b0,1'b1,1'b1,1'b0,16'hBEEF,16'h0000,16'h0040,16'h0000};
        tv[5]  = '{mk(1'b1,1'b0,16'h0010,16'h1234,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b1,1'b0,16'hBEEF,16'h0000,16'h0040,16'h0000};
        tv[6]  = '{mk(1'b1,1'b0,16'h0010,16'h1234,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b0,1'b0,16'hBEEF,16'h0000,16'h0010,16'h1234};
        tv[7]  = '{mk(1'b1,1'b0,16'h0010,16'h1234,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b0,1'b0,16'hBEEF,16'h0000,16'h0010,16'h1234};
        tv[8]  = '{mk(1'b1,1'b0,16'h0010,16'h1234,1'b0,1'b0,16'h0,16'h0), 1'b0,1'b1,1'b0,1'b0,16'hBEEF,16'h0000,16'h0010,16'h1234};
        tv[9]  = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b0,1'b1,1'b1,1'b0,16'hBEEF,16'h0000,16'h0010,16'h1234};
        tv[10] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b1,1'b0,16'h0020,16'h0), 1'b0,1'b1,1'b1,1'b0,16'hBEEF,16'h0000,16'h0010,16'h1234};
        tv[11] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b1,1'b0,16'h0020,16'h0), 1'b0,1'b0,1'b1,1'b0,16'hBEEF,16'h0000,16'h0020,16'h0000};
        tv[12] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b1,1'b0,16'h0020,16'h0), 1'b0,1'b0,1'b1,1'b0,16'hBEEF,16'h0000,16'h0020,16'h0000};
        tv[13] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b1,1'b0,16'h0020,16'h5A5A), 1'b0,1'b0,1'b1,1'b1,16'hBEEF,16'h5A5A,16'h0020,16'h0000};
        tv[14] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b0,1'b0,16'h0000,16'h0), 1'b0,1'b1,1'b1,1'b0,16'hBEEF,16'h5A5A,16'h0020,16'h0000};
        tv[15] = '{mk(1'b0,1'b0,16'h0030,16'h7777,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b1,1'b0,16'hBEEF,16'h5A5A,16'h0020,16'h0000};
        tv[16] = '{mk(1'b0,1'b0,16'h0030,16'h7777,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b0,1'b0,16'hBEEF,16'h5A5A,16'h0030,16'h7777};
        tv[17] = '{mk(1'b0,1'b0,16'h0030,16'h7777,1'b0,1'b0,16'h0,16'h0), 1'b1,1'b1,1'b0,1'b0,16'hBEEF,16'h5A5A,16'h0030,16'h7777};
        tv[18] = '{mk(1'b0,1'b0,16'h0030,16'h7777,1'b0,1'b0,16'h0,16'hDEAD), 1'b0,1'b1,1'b0,1'b0,16'hBEEF,16'h5A5A,16'h0030,16'h7777};
        tv[19] = '{mk(1'b1,1'b1,16'h0000,16'h0,1'b0,1'b0,16'h0,16'h0000), 1'b0,1'b1,1'b1,1'b0,16'hBEEF,16'h5A5A,16'h0030,16'h7777};

        for (int k = 0; k < 20; k++) begin
            step(tv[k].i);
            chk($sformatf("tv%0d stall", k), 16'(bus.cpu_stall), 16'(tv[k].stall));
            chk($sformatf("tv%0d re_L", k),  16'(bus.mem_re_L),  16'(tv[k].mre));
            chk($sformatf("tv%0d we_L", k),  16'(bus.mem_we_L),  16'(tv[k].mwe));
            chk($sformatf("tv%0d ack", k),   16'(bus.dbg_ack),   16'(tv[k].ack));
            chk($sformatf("tv%0d cpu_rdata", k), bus.cpu_rdata, tv[k].crd);
            chk($sformatf("tv%0d dbg_rdata", k), bus.dbg_rdata, tv[k].drd);
            chk($sformatf("tv%0d mem_addr", k),  bus.mem_addr,  tv[k].maddr);
            chk($sformatf("tv%0d mem_wdata", k), bus.mem_wdata, tv[k].mwd);
        end

        // CPU hammers the port while debug waits: CPU twice, then debug; twice over.
        s = mk(1'b0, 1'b1, 16'h0100, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h1111);
        for (int rep = 0; rep < 2; rep++) begin
            ack_k = -1;
            done1 = -1;
            done2 = -1;
            for (int k = 0; k < 20 && ack_k < 0; k++) begin
                step(s);
                if (!bus.cpu_stall) begin
                    if (done1 < 0)      done1 = k;
                    else if (done2 < 0) done2 = k;
                end
                if (bus.dbg_ack) ack_k = k;
            end
            chk($sformatf("starve%0d cpu done 1", rep), 16'(done1), 16'd3);
            chk($sformatf("starve%0d cpu done 2", rep), 16'(done2), 16'd7);
            chk($sformatf("starve%0d dbg ack", rep),    16'(ack_k), 16'd11);
            step(idle);
            step(idle);
        end

        // Asynchronous reset in the middle of a CPU write, request held throughout.
        s = mk(1'b1, 1'b0, 16'h0050, 16'hCAFE, 1'b0, 1'b0, 16'h0, 16'h0);
        step(s);
        step(s);
        step(s);
        chk("pre-reset we_L", 16'(bus.mem_we_L), 16'd0);
        rst = 1'b1;
        #1;
        chk("async reset we_L",  16'(bus.mem_we_L),  16'd1);
        chk("async reset re_L",  16'(bus.mem_re_L),  16'd1);
        chk("async reset addr",  bus.mem_addr,  16'h0000);
        chk("async reset wdata", bus.mem_wdata, 16'h0000);
        chk("async reset stall", 16'(bus.cpu_stall), 16'd1);
        chk("async reset cpu_rdata", bus.cpu_rdata, 16'h0000);
        s.rst = 1'b1;
        step(s);
        s.rst = 1'b0;
        lowcnt = 0;
        stall_done = -1;
        for (int k = 0; k < 10 && stall_done < 0; k++) begin
            step(s);
            if (!bus.mem_we_L) lowcnt++;
            if (!bus.cpu_stall) stall_done = k;
        end
        chk("restart we_L cycles", 16'(lowcnt), 16'd3);
        chk("restart stall done",  16'(stall_done), 16'd3);
        step(idle);

        for (int k = 0; k < 400; k++) begin
            in_t r;
            r.rst   = ($urandom_range(0, 63) == 0);
            r.re_l  = 1'($urandom_range(0, 1));
            r.we_l  = ($urandom_range(0, 3) != 0);
            r.caddr = 16'($urandom);
            r.cwd   = 16'($urandom);
            r.dreq  = ($urandom_range(0, 2) == 0);
            r.dwe   = 1'($urandom_range(0, 1));
            r.daddr = 16'($urandom);
            r.dwd   = 16'($urandom);
            r.mrd   = 16'($urandom);
            step(r);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
